// File: rtl/alu_pkg.sv
// Shared types for the ALU command path: operation encoding, command word,
// and the sequencer FSM state.
package alu_pkg;
   localparam int ALU_IN_W  = 8;
   localparam int ALU_OUT_W = 9;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_op_e;

   typedef struct packed {
      alu_op_e             op;
      logic [ALU_IN_W-1:0] a;
      logic [ALU_IN_W-1:0] b;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } seq_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; one extra pointer bit tells full from empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_push,
   input  alu_cmd_t i_data,
   input  logic     i_pop,
   output alu_cmd_t o_data,
   output logic     o_full,
   output logic     o_empty
);
   localparam int AW = $clog2(CMD_DEPTH);
   localparam int PW = AW + 1;

   alu_cmd_t         r_mem [CMD_DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end for the registered 8-bit ALU: queue commands, issue one at
// a time, capture the 9-bit result and hand it off with backpressure.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [ALU_IN_W-1:0]  cmd_a,
   input  logic [ALU_IN_W-1:0]  cmd_b,
   output logic [ALU_IN_W-1:0]  alu_a,
   output logic [ALU_IN_W-1:0]  alu_b,
   output logic [1:0]           alu_sel,
   input  logic [ALU_OUT_W-1:0] alu_result,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ALU_OUT_W-1:0] res_data,
   output logic                 res_zero,
   output logic                 busy,
   output logic [CNT_W-1:0]     ops_done
);
   seq_state_e r_state;
   alu_cmd_t   w_cmd_in;
   alu_cmd_t   w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_pop;

   assign w_cmd_in  = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
   assign cmd_ready = !w_full;
   assign busy      = (r_state != S_IDLE) || !w_empty;
   // Pop exactly on the edges where the FSM loads the next operation.
   assign w_pop     = !w_empty && ((r_state == S_IDLE) ||
                                   ((r_state == S_RESP) && res_ready));

   alu_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (cmd_valid),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_zero  <= 1'b0;
         ops_done  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  alu_a   <= w_head.a;
                  alu_b   <= w_head.b;
                  alu_sel <= w_head.op;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               res_data  <= alu_result;
               res_zero  <= (alu_result == '0);
               res_valid <= 1'b1;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  ops_done  <= ops_done + CNT_W'(1);
                  if (w_pop) begin
                     alu_a   <= w_head.a;
                     alu_b   <= w_head.b;
                     alu_sel <= w_head.op;
                     r_state <= S_ISSUE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a queue-based
// reference, with a behavioural registered ALU attached to its ALU ports.
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [7:0]  cmd_a = '0;
   logic [7:0]  cmd_b = '0;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [1:0]  alu_sel;
   logic [8:0]  alu_result;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [8:0]  res_data;
   logic        res_zero;
   logic        busy;
   logic [15:0] ops_done;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [8:0]  exp_q[$];
   logic [8:0]  got_q[$];
   int          hand_cyc[$];
   logic [15:0] exp_ops = '0;

   alu_op_sequencer #(.CMD_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .busy(busy), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] calc(logic [1:0] op, logic [7:0] a, logic [7:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'd0:    r = ia + ib;
         2'd1:    r = ia - ib;
         2'd2:    r = ia & ib;
         default: r = ia | ib;
      endcase
      return 9'(r & 511);
   endfunction

   // Registered ALU sharing clock and reset with the sequencer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) alu_result <= '0;
      else        alu_result <= calc(alu_sel, alu_a, alu_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: update the reference from the handshakes seen before the edge.
   task automatic step();
      logic       pv, rv, hold;
      logic [8:0] hd, e;
      pv   = cmd_valid && cmd_ready;
      rv   = res_valid && res_ready;
      hold = res_valid && !res_ready;
      hd   = res_data;
      if (pv) exp_q.push_back(calc(cmd_op, cmd_a, cmd_b));
      if (rv) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(res_data), 32'h1ff_dead);
         end else begin
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e));
            chk("res_zero", 32'(res_zero), 32'(e == 9'd0));
         end
         got_q.push_back(res_data);
         hand_cyc.push_back(cyc);
         exp_ops = exp_ops + 16'd1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hold && rst_n) begin
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_data", 32'(res_data), 32'(hd));
      end
      chk("ops_done", 32'(ops_done), 32'(exp_ops));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
      chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
      chk({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"},  32'(res_data),  32'd0);
      chk({tag, "_res_zero"},  32'(res_zero),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_ops_done"},  32'(ops_done),  32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      #2;
      chk_reset_vals(tag);
      exp_q.delete();
      got_q.delete();
      hand_cyc.delete();
      exp_ops = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      cmd_op = op;
      cmd_a  = a;
      cmd_b  = b;
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || res_valid) && n < max_cyc) begin
         step();
         n++;
      end
      chk({tag, "_drain_timeout"}, 32'(n < max_cyc), 32'd1);
   endtask

   initial begin
      int n_acc, sent;
      logic acc;

      // Reset state
      do_reset("rst");
      chk_reset_vals("post_rst");

      // Single ADD with carry; latency of 3 edges after the push edge
      set_cmd(2'd0, 8'hFF, 8'h01);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("add_lat_e0", 32'(res_valid), 32'd0);
      step();
      chk("add_lat_e1", 32'(res_valid), 32'd0);
      step();
      chk("add_lat_e2", 32'(res_valid), 32'd0);
      step();
      chk("add_lat_e3", 32'(res_valid), 32'd1);
      chk("add_data", 32'(res_data), 32'h100);
      chk("add_zero", 32'(res_zero), 32'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("add_ops", 32'(ops_done), 32'd1);

      // SUB wrap, then zero result
      do_reset("rst2");
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      set_cmd(2'd1, 8'd3, 8'd5);
      step();
      set_cmd(2'd1, 8'd7, 8'd7);
      step();
      cmd_valid = 1'b0;
      drain("sub", 40);
      chk("sub_cnt", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("sub_wrap", 32'(got_q[0]), 32'h1FE);
         chk("sub_zero_val", 32'(got_q[1]), 32'h000);
      end

      // Backpressure: 5 accepted (4 queued + 1 in flight), then refused
      do_reset("rst3");
      n_acc = 0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_cmd(2'(i), 8'(i * 17 + 200), 8'(i + 3));
         acc = cmd_ready;
         step();
         if (acc) n_acc++;
      end
      cmd_valid = 1'b0;
      chk("bp_accepts", 32'(n_acc), 32'd5);
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 5; i++) step();
      res_ready = 1'b1;
      drain("bp", 60);
      chk("bp_ops", 32'(ops_done), 32'd5);
      chk("bp_results", 32'(got_q.size()), 32'd5);

      // Back-to-back throughput
      do_reset("rst4");
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      set_cmd(2'd2, 8'hF0, 8'h3C);
      step();
      set_cmd(2'd3, 8'hF0, 8'h0F);
      step();
      cmd_valid = 1'b0;
      drain("tp", 40);
      chk("tp_cnt", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("tp_and", 32'(got_q[0]), 32'h030);
         chk("tp_or", 32'(got_q[1]), 32'h0FF);
         chk("tp_spacing", 32'(hand_cyc[1] - hand_cyc[0]), 32'd3);
      end

      // Reset in WAIT with two commands queued
      do_reset("rst5");
      cmd_valid = 1'b1;
      set_cmd(2'd0, 8'd1, 8'd2);
      step();
      set_cmd(2'd1, 8'd9, 8'd4);
      step();
      set_cmd(2'd3, 8'h11, 8'h22);
      step();
      cmd_valid = 1'b0;
      chk("mid_busy", 32'(busy), 32'd1);
      do_reset("mid_rst");
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("mid_no_valid", 32'(res_valid), 32'd0);
      end
      cmd_valid = 1'b1;
      set_cmd(2'd0, 8'h40, 8'h02);
      step();
      cmd_valid = 1'b0;
      drain("mid_new", 40);
      chk("mid_new_ops", 32'(ops_done), 32'd1);
      if (got_q.size() == 1) chk("mid_new_data", 32'(got_q[0]), 32'h042);
      else chk("mid_new_cnt", 32'(got_q.size()), 32'd1);

      // Randomized traffic with random backpressure
      do_reset("rst6");
      sent = 0;
      for (int c = 0; c < 3000 && (sent < 60 || exp_q.size() != 0 || res_valid); c++) begin
         if (!cmd_valid && sent < 60 && ($urandom_range(0, 1) == 1)) begin
            cmd_valid = 1'b1;
            set_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
         end
         res_ready = ($urandom_range(0, 2) != 0);
         acc = cmd_valid && cmd_ready;
         step();
         if (acc) begin
            sent++;
            cmd_valid = 1'b0;
         end
      end
      chk("rnd_sent", 32'(sent), 32'd60);
      chk("rnd_left", 32'(exp_q.size()), 32'd0);
      chk("rnd_ops", 32'(ops_done), 32'd60);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
